// File: rtl/jk_updown_counter_pkg.sv
// rtl/jk_updown_counter_pkg.sv - shared constants for the JK up/down counter
// Purpose: direction constants and the {J,K} action encodings shared by the
//          counter top level and its JK flip-flop cells.
// Ports:   none (package).
package jk_updown_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Encoded as {J,K} so bit 1 drives J and bit 0 drives K directly.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_action_e;

endpackage

// File: rtl/jk_updown_counter_if.sv
// rtl/jk_updown_counter_if.sv - control/status bundle of the JK up/down counter
// Purpose: groups the counter controls and status outputs.
// Ports:   master drives en, up_dn, load, load_val and observes count, tc,
//          wrap, load_err; slave (the counter) is the mirror image.
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/jk_ff_sync.sv
// rtl/jk_ff_sync.sv - JK flip-flop with synchronous active-high reset
// Purpose: one storage cell of the counter.
// Ports:   clk (clock), rst (sync reset to 0), J, K (cell drive), Q (state).
module jk_ff_sync
    import jk_updown_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= 1'b0;
        end else begin
            case (jk_action_e'({J, K}))
                JK_SET:  Q <= 1'b1;
                JK_CLR:  Q <= 1'b0;
                JK_TOG:  Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - modulo-MODULUS up/down counter built from JK cells
// Purpose: synchronous up/down counter with clamped parallel load; each count
//          bit lives in a jk_ff_sync cell whose J/K drive is derived here.
// Ports:   clk (clock), rst (sync active-high reset),
//          bus (slave): en, up_dn, load, load_val in; count, tc (combinational
//          terminal count), wrap and load_err (registered 1-cycle pulses) out.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                clk,
    input  logic                rst,
    jk_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is still representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] load_v;
    logic             clamp;
    logic             wrap_d;
    logic             wrap_q;
    logic             load_err_q;

    // Load value, clamped to the top of the range when out of range.
    always_comb begin
        load_v = bus.load_val;
        clamp  = 1'b0;
        if ({1'b0, bus.load_val} >= MOD_EXT) begin
            load_v = MAX_VAL;
            clamp  = 1'b1;
        end
    end

    // Counting next value; a count above MAX_VAL only arises from an illegal
    // parameter choice and is forced back to 0 in either direction.
    always_comb begin
        next_cnt = count;
        wrap_d   = 1'b0;
        if (bus.up_dn == DIR_UP) begin
            if (count == MAX_VAL) begin
                next_cnt = '0;
                wrap_d   = 1'b1;
            end else if (count < MAX_VAL) begin
                next_cnt = count + 1'b1;
            end else begin
                next_cnt = '0;
            end
        end else begin
            if (count == '0) begin
                next_cnt = MAX_VAL;
                wrap_d   = 1'b1;
            end else if (count > MAX_VAL) begin
                next_cnt = '0;
            end else begin
                next_cnt = count - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_action_e act;

        // Load forces each bit (set/clear); counting toggles only changing bits.
        always_comb begin
            act = JK_HOLD;
            if (bus.load) begin
                act = load_v[i] ? JK_SET : JK_CLR;
            end else if (bus.en && (next_cnt[i] != count[i])) begin
                act = JK_TOG;
            end
        end

        jk_ff_sync u_cell (
            .clk (clk),
            .rst (rst),
            .J   (act[1]),
            .K   (act[0]),
            .Q   (count[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= !bus.load && bus.en && wrap_d;
            load_err_q <= bus.load && clamp;
        end
    end

    assign bus.count    = count;
    assign bus.tc       = (bus.up_dn == DIR_UP) ? (count == MAX_VAL) : (count == '0);
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb/tb_jk_updown_counter.sv - self-checking bench for jk_updown_counter
module tb_jk_updown_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    typedef struct {
        string      tag;
        logic [3:0] count;
        logic       tc;
        logic       wrap;
        logic       load_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jk_updown_counter_if #(.WIDTH(WIDTH)) bus ();

    jk_updown_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   m_count = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // Drive one edge's inputs, push the model's post-edge result, then pop and
    // compare once the DUT has taken the edge.
    task automatic step(input string tag, input bit r, input bit e, input bit u,
                        input bit l, input int lv);
        exp_t x;
        int   w;
        int   le;
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.up_dn    = u;
        bus.load     = l;
        bus.load_val = 4'(lv);
        w  = 0;
        le = 0;
        if (r) begin
            m_count = 0;
        end else if (l) begin
            if (lv < MODULUS) begin
                m_count = lv;
            end else begin
                m_count = MODULUS - 1;
                le      = 1;
            end
        end else if (e) begin
            if (u) begin
                if (m_count == MODULUS - 1) begin
                    m_count = 0;
                    w       = 1;
                end else begin
                    m_count = m_count + 1;
                end
            end else begin
                if (m_count == 0) begin
                    m_count = MODULUS - 1;
                    w       = 1;
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
        x.tag      = tag;
        x.count    = 4'(m_count);
        x.tc       = u ? (m_count == MODULUS - 1) : (m_count == 0);
        x.wrap     = 1'(w);
        x.load_err = 1'(le);
        exp_q.push_back(x);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            check({x.tag, "_count"},    32'(bus.count),    32'(x.count));
            check({x.tag, "_tc"},       32'(bus.tc),       32'(x.tc));
            check({x.tag, "_wrap"},     32'(bus.wrap),     32'(x.wrap));
            check({x.tag, "_load_err"}, 32'(bus.load_err), 32'(x.load_err));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'd5;

        // Reset beats load and count.
        step("rst0", 1, 1, 1, 1, 5);
        step("rst1", 1, 1, 1, 1, 5);

        // Count up through a full cycle.
        for (int i = 0; i < 10; i++) step("up", 0, 1, 1, 0, 0);
        check("up_end_count", 32'(bus.count), 32'd0);
        check("up_end_wrap", 32'(bus.wrap), 32'd1);

        // Count down wraps 0 -> 9, then 8, 7.
        step("dn_wrap", 0, 1, 0, 0, 0);
        check("dn_wrap_count", 32'(bus.count), 32'd9);
        step("dn8", 0, 1, 0, 0, 0);
        step("dn7", 0, 1, 0, 0, 0);

        // Loads: in range, clamped, boundary values, load ignores en.
        step("ld7", 0, 0, 1, 1, 7);
        step("ld12", 0, 0, 1, 1, 12);
        check("ld12_err", 32'(bus.load_err), 32'd1);
        step("ld_hold", 0, 0, 1, 0, 0);
        step("ld10", 0, 1, 1, 1, 10);
        step("ld9", 0, 1, 1, 1, 9);
        step("ld15_en", 0, 1, 0, 1, 15);
        step("ld0", 0, 1, 0, 1, 0);

        // Hold at 4 for five cycles.
        step("ld4", 0, 0, 1, 1, 4);
        for (int i = 0; i < 5; i++) step("hold4", 0, 0, i[0], 0, 0);
        check("hold_count", 32'(bus.count), 32'd4);

        // Direction change takes effect on the same edge.
        step("to5", 0, 1, 1, 0, 0);
        step("to6", 0, 1, 1, 0, 0);
        step("back5", 0, 1, 0, 0, 0);
        step("up6", 0, 1, 1, 0, 0);

        // Reset during load: no pulses, counting resumes from 0.
        step("rst_ld", 1, 0, 1, 1, 3);
        check("rst_ld_count", 32'(bus.count), 32'd0);
        step("resume1", 0, 1, 1, 0, 0);
        step("resume2", 0, 1, 1, 0, 0);

        // Load at the top of range with en high never produces wrap.
        step("ld9_wrapless", 0, 1, 1, 1, 9);
        step("wrap_again", 0, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
